// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: scan controller for a shared programmable 5-bit sequence detector.
//
// Holds a NUM_PAT-entry table of {enable, pattern}. A start request walks the
// table, and for every enabled entry it reloads the detector, streams a
// WIN_LEN-bit gap-free window into it, counts detector hits and emits one
// per-pattern report.
//
// Optional feature macro: SEQ_DET_CTRL_LOOP_EN
//   defined   - after the last index, rescan from index 0 while start is held
//   undefined - single pass per start pulse
//
// Ports
//   clk, resetn                  clock, synchronous active-low reset
//   cfg_we/cfg_idx/cfg_pat/cfg_en table write (accepted in IDLE only)
//   start                        begin a scan pass
//   busy, done                   status; done is a one-cycle end-of-pass pulse
//   din_valid, din, din_ready    serial input bit stream
//   det_resetn, det_init         detector reload (active-low) and target pattern
//   det_din, det_seen            detector input bit and registered hit flag
//   hit_valid/hit_idx/hit_cnt    per-pattern report strobe, index and hit count

module seq_det_ctrl #(
   parameter int unsigned NUM_PAT = 4,
   parameter int unsigned WIN_LEN = 32,
   parameter int unsigned CNT_W   = 8,
   localparam int unsigned IW     = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             cfg_we,
   input  logic [IW-1:0]    cfg_idx,
   input  logic [4:0]       cfg_pat,
   input  logic             cfg_en,
   input  logic             start,
   output logic             busy,
   output logic             done,
   input  logic             din_valid,
   input  logic             din,
   output logic             din_ready,
   output logic             det_resetn,
   output logic [4:0]       det_init,
   output logic             det_din,
   input  logic             det_seen,
   output logic             hit_valid,
   output logic [IW-1:0]    hit_idx,
   output logic [CNT_W-1:0] hit_cnt
);

   // Scan index carries one extra value (NUM_PAT) marking "table exhausted".
   localparam int unsigned XW = $clog2(NUM_PAT + 1);
   localparam int unsigned BW = $clog2(WIN_LEN + 1);

   localparam logic [XW-1:0]    LAST_IDX = XW'(NUM_PAT - 1);
   localparam logic [XW-1:0]    END_IDX  = XW'(NUM_PAT);
   localparam logic [BW-1:0]    WIN_END  = BW'(WIN_LEN);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEEK,
      S_LOAD,
      S_SCAN,
      S_DRAIN,
      S_REPORT,
      S_DONE
   } state_t;

   // Pattern table
   logic [4:0]         r_pat [NUM_PAT];
   logic [NUM_PAT-1:0] r_en;

   // Control state
   state_t             r_state;
   state_t             w_state_nxt;
   logic [XW-1:0]      r_idx;
   logic [XW-1:0]      w_idx_nxt;
   logic [IW-1:0]      w_cur_idx;
   logic [BW-1:0]      r_bit_cnt;
   logic [BW-1:0]      w_bit_cnt_nxt;
   logic [CNT_W-1:0]   r_acc;
   logic [CNT_W-1:0]   w_acc_nxt;
   logic               w_count_hit;

   // Registered outputs
   logic               r_busy;
   logic               r_done;
   logic               r_din_ready;
   logic               r_det_load;
   logic [4:0]         r_det_init;
   logic               r_hit_valid;
   logic [IW-1:0]      r_hit_idx;
   logic [CNT_W-1:0]   r_hit_cnt;

   assign w_cur_idx = r_idx[IW-1:0];

   // Table write port, accepted only while idle
   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int i = 0; i < int'(NUM_PAT); i++) begin
            r_pat[i] <= '0;
         end
         r_en <= '0;
      end else if (cfg_we && (r_state == S_IDLE) && (32'(cfg_idx) < NUM_PAT)) begin
         r_pat[cfg_idx] <= cfg_pat;
         r_en[cfg_idx]  <= cfg_en;
      end
   end

   // Next-state, index, bit counter and hit accumulator
   always_comb begin
      w_state_nxt   = r_state;
      w_idx_nxt     = r_idx;
      w_bit_cnt_nxt = r_bit_cnt;
      w_acc_nxt     = r_acc;
      w_count_hit   = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_SEEK;
               w_idx_nxt   = '0;
            end
         end

         // One table entry examined per cycle; END_IDX means nothing left.
         S_SEEK: begin
            if (r_idx == END_IDX) begin
               w_state_nxt = S_DONE;
            end else if (r_en[w_cur_idx]) begin
               w_state_nxt = S_LOAD;
            end else begin
               w_idx_nxt = r_idx + XW'(1);
            end
         end

         S_LOAD: begin
            w_bit_cnt_nxt = '0;
            w_acc_nxt     = '0;
            w_state_nxt   = S_SCAN;
         end

         // A gap aborts the window; the detector is reloaded for the same entry.
         // det_seen in the first window cycle predates any window bit.
         S_SCAN: begin
            if (!din_valid) begin
               w_state_nxt = S_LOAD;
            end else begin
               w_count_hit   = (r_bit_cnt != '0);
               w_bit_cnt_nxt = r_bit_cnt + BW'(1);
               if (w_bit_cnt_nxt == WIN_END) begin
                  w_state_nxt = S_DRAIN;
               end
            end
         end

         // Captures the hit produced by the last window bit.
         S_DRAIN: begin
            w_count_hit = 1'b1;
            w_state_nxt = S_REPORT;
         end

         S_REPORT: begin
            if (r_idx == LAST_IDX) begin
`ifdef SEQ_DET_CTRL_LOOP_EN
               if (start) begin
                  w_state_nxt = S_SEEK;
                  w_idx_nxt   = '0;
               end else begin
                  w_state_nxt = S_DONE;
               end
`else
               w_state_nxt = S_DONE;
`endif
            end else begin
               w_state_nxt = S_SEEK;
               w_idx_nxt   = r_idx + XW'(1);
            end
         end

         S_DONE: begin
            w_state_nxt = S_IDLE;
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      // Saturating hit counter
      if (w_count_hit && det_seen && (r_acc != CNT_MAX)) begin
         w_acc_nxt = r_acc + CNT_W'(1);
      end
   end

   // State and output registers; outputs are decoded from the next state
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state     <= S_IDLE;
         r_idx       <= '0;
         r_bit_cnt   <= '0;
         r_acc       <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_din_ready <= 1'b0;
         r_det_load  <= 1'b0;
         r_det_init  <= '0;
         r_hit_valid <= 1'b0;
         r_hit_idx   <= '0;
         r_hit_cnt   <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_idx       <= w_idx_nxt;
         r_bit_cnt   <= w_bit_cnt_nxt;
         r_acc       <= w_acc_nxt;
         r_busy      <= (w_state_nxt != S_IDLE);
         r_done      <= (w_state_nxt == S_DONE);
         r_din_ready <= (w_state_nxt == S_SCAN);
         r_det_load  <= (w_state_nxt == S_LOAD);
         r_hit_valid <= (w_state_nxt == S_REPORT);
         if (w_state_nxt == S_LOAD) begin
            r_det_init <= r_pat[w_cur_idx];
         end
         if (w_state_nxt == S_REPORT) begin
            r_hit_idx <= w_cur_idx;
            r_hit_cnt <= w_acc_nxt;
         end
      end
   end

   assign busy       = r_busy;
   assign done       = r_done;
   assign din_ready  = r_din_ready;
   // Detector held in reset while the controller itself is in reset.
   assign det_resetn = resetn & ~r_det_load;
   assign det_init   = r_det_init;
   // Bit passes straight through to the detector while scanning.
   assign det_din    = r_din_ready & din;
   assign hit_valid  = r_hit_valid;
   assign hit_idx    = r_hit_idx;
   assign hit_cnt    = r_hit_cnt;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Testbench for seq_det_ctrl: two instances (CNT_W = 8 and CNT_W = 2) share
// stimulus, each driving its own behavioural 5-bit sequence detector.

module tb_seq_det_ctrl;

   localparam int unsigned NUM_PAT = 4;
   localparam int unsigned WIN_LEN = 32;
   localparam int unsigned IW      = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          resetn;
   logic          cfg_we;
   logic [IW-1:0] cfg_idx;
   logic [4:0]    cfg_pat;
   logic          cfg_en;
   logic          start;
   logic          din_valid;
   logic          din;

   logic          busy_a, done_a, din_ready_a, det_resetn_a, det_din_a, det_seen_a, hit_valid_a;
   logic [4:0]    det_init_a;
   logic [IW-1:0] hit_idx_a;
   logic [7:0]    hit_cnt_a;

   logic          busy_b, done_b, din_ready_b, det_resetn_b, det_din_b, det_seen_b, hit_valid_b;
   logic [4:0]    det_init_b;
   logic [IW-1:0] hit_idx_b;
   logic [1:0]    hit_cnt_b;

   seq_det_ctrl #(.NUM_PAT(NUM_PAT), .WIN_LEN(WIN_LEN), .CNT_W(8)) u_dut_a (
      .clk(clk), .resetn(resetn),
      .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pat(cfg_pat), .cfg_en(cfg_en),
      .start(start), .busy(busy_a), .done(done_a),
      .din_valid(din_valid), .din(din), .din_ready(din_ready_a),
      .det_resetn(det_resetn_a), .det_init(det_init_a), .det_din(det_din_a),
      .det_seen(det_seen_a),
      .hit_valid(hit_valid_a), .hit_idx(hit_idx_a), .hit_cnt(hit_cnt_a)
   );

   seq_det_ctrl #(.NUM_PAT(NUM_PAT), .WIN_LEN(WIN_LEN), .CNT_W(2)) u_dut_b (
      .clk(clk), .resetn(resetn),
      .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pat(cfg_pat), .cfg_en(cfg_en),
      .start(start), .busy(busy_b), .done(done_b),
      .din_valid(din_valid), .din(din), .din_ready(din_ready_b),
      .det_resetn(det_resetn_b), .det_init(det_init_b), .det_din(det_din_b),
      .det_seen(det_seen_b),
      .hit_valid(hit_valid_b), .hit_idx(hit_idx_b), .hit_cnt(hit_cnt_b)
   );

   // Behavioural detectors: hit registered the cycle after the 5th matching bit
   logic [4:0] sh_a, pat_a, sh_b, pat_b;
   logic [2:0] nb_a, nb_b;

   always @(posedge clk) begin
      if (!det_resetn_a) begin
         sh_a <= '0; nb_a <= '0; pat_a <= det_init_a; det_seen_a <= 1'b0;
      end else begin
         sh_a <= {sh_a[3:0], det_din_a};
         if (nb_a < 3'd5) nb_a <= nb_a + 3'd1;
         det_seen_a <= (nb_a >= 3'd4) && ({sh_a[3:0], det_din_a} == pat_a);
      end
   end

   always @(posedge clk) begin
      if (!det_resetn_b) begin
         sh_b <= '0; nb_b <= '0; pat_b <= det_init_b; det_seen_b <= 1'b0;
      end else begin
         sh_b <= {sh_b[3:0], det_din_b};
         if (nb_b < 3'd5) nb_b <= nb_b + 3'd1;
         det_seen_b <= (nb_b >= 3'd4) && ({sh_b[3:0], det_din_b} == pat_b);
      end
   end

   int            n_checks, n_errors;
   int            cyc, n_hit, n_done, n_load, rep_cyc, done_cyc, ptr, gap_at;
   logic [31:0]   win;
   logic [IW-1:0] last_idx;
   logic [7:0]    last_cnt_a;
   logic [1:0]    last_cnt_b;
   logic [4:0]    last_init;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one cycle: sample outputs at negedge, then drive the bit source
   task automatic tick();
      @(negedge clk);
      cyc++;
      if (hit_valid_a) begin
         n_hit++; rep_cyc = cyc; last_idx = hit_idx_a;
         last_cnt_a = hit_cnt_a; last_cnt_b = hit_cnt_b;
      end
      if (done_a) begin
         n_done++; done_cyc = cyc;
      end
      if (!det_resetn_a && resetn) begin
         n_load++; last_init = det_init_a;
      end
      if (din_ready_a) begin
         if (ptr == gap_at) begin
            din_valid = 1'b0; din = 1'b0; gap_at = -1;
         end else begin
            din_valid = 1'b1; din = win[31-ptr]; ptr++;
         end
      end else begin
         din_valid = 1'b0; din = 1'b0; ptr = 0;
      end
   endtask

   task automatic cfg_write(input int idx, input logic [4:0] pat, input logic en);
      cfg_we = 1'b1; cfg_idx = IW'(idx); cfg_pat = pat; cfg_en = en;
      tick();
      cfg_we = 1'b0;
   endtask

   // One start pulse; cyc counts cycles after the edge that sampled start
   task automatic run_pass(input int budget, input bit busy_wr);
      n_hit = 0; n_done = 0; n_load = 0; cyc = 0; rep_cyc = -1; done_cyc = -1;
      start = 1'b1;
      tick();
      start = 1'b0;
      while (n_done == 0 && cyc < budget) begin
         cfg_we = 1'b0;
         if (busy_wr && cyc == 5) begin
            cfg_we = 1'b1; cfg_idx = IW'(0); cfg_pat = 5'b00000; cfg_en = 1'b0;
         end
         if (busy_wr && cyc == 6) begin
            cfg_we = 1'b1; cfg_idx = IW'(3); cfg_pat = 5'b11111; cfg_en = 1'b1;
         end
         tick();
      end
      cfg_we = 1'b0;
      check_val("done_seen", n_done, 32'd1);
      check_val("busy_at_done", 32'(busy_a), 32'd1);
      tick();
      check_val("busy_after_done", 32'(busy_a), 32'd0);
   endtask

   localparam logic [31:0] WIN_TWO = 32'b000_10110_000000000000_10110_0000000;

   initial begin
      n_checks = 0; n_errors = 0;
      resetn = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_pat = '0; cfg_en = 1'b0;
      start = 1'b0; din_valid = 1'b0; din = 1'b0;
      win = '0; ptr = 0; gap_at = -1; cyc = 0;
      n_hit = 0; n_done = 0; n_load = 0; rep_cyc = -1; done_cyc = -1;
      last_idx = '0; last_cnt_a = '0; last_cnt_b = '0; last_init = '0;

      // Reset values
      repeat (3) tick();
      check_val("rst_busy",       32'(busy_a),       32'd0);
      check_val("rst_done",       32'(done_a),       32'd0);
      check_val("rst_din_ready",  32'(din_ready_a),  32'd0);
      check_val("rst_det_resetn", 32'(det_resetn_a), 32'd0);
      check_val("rst_det_init",   32'(det_init_a),   32'd0);
      check_val("rst_det_din",    32'(det_din_a),    32'd0);
      check_val("rst_hit_valid",  32'(hit_valid_a),  32'd0);
      check_val("rst_hit_idx",    32'(hit_idx_a),    32'd0);
      check_val("rst_hit_cnt",    32'(hit_cnt_a),    32'd0);
      resetn = 1'b1;
      tick();
      check_val("post_rst_det_resetn", 32'(det_resetn_a), 32'd1);

      // Entry 0 = 10110, two occurrences in the window
      cfg_write(0, 5'b10110, 1'b1);
      win = WIN_TWO;
      run_pass(200, 1'b0);
      check_val("t1_nhit",   n_hit, 32'd1);
      check_val("t1_idx",    32'(last_idx), 32'd0);
      check_val("t1_cnt",    32'(last_cnt_a), 32'd2);
      check_val("t1_cnt_b",  32'(last_cnt_b), 32'd2);
      check_val("t1_rep_cyc", rep_cyc, 32'd36);
      check_val("t1_done_cyc", done_cyc, 32'd41);
      check_val("t1_nload",  n_load, 32'd1);
      check_val("t1_init",   32'(last_init), 32'(5'b10110));
      check_val("t1_hold_idx", 32'(hit_idx_a), 32'd0);
      check_val("t1_hold_cnt", 32'(hit_cnt_a), 32'd2);

      // Entry 2 = 11111, overlapping matches from 7 ones
      cfg_write(0, 5'b10110, 1'b0);
      cfg_write(2, 5'b11111, 1'b1);
      win = 32'hFE00_0000;
      run_pass(200, 1'b0);
      check_val("t2_nhit",   n_hit, 32'd1);
      check_val("t2_idx",    32'(last_idx), 32'd2);
      check_val("t2_cnt",    32'(last_cnt_a), 32'd3);
      check_val("t2_cnt_b",  32'(last_cnt_b), 32'd3);
      check_val("t2_rep_cyc", rep_cyc, 32'd38);
      check_val("t2_done_cyc", done_cyc, 32'd41);

      // Match ending on the last window bit is captured in DRAIN
      win = 32'h0000_001F;
      run_pass(200, 1'b0);
      check_val("t2b_cnt",   32'(last_cnt_a), 32'd1);
      check_val("t2b_cnt_b", 32'(last_cnt_b), 32'd1);

      // All entries disabled
      cfg_write(2, 5'b11111, 1'b0);
      run_pass(50, 1'b0);
      check_val("t3_nhit",     n_hit, 32'd0);
      check_val("t3_done_cyc", done_cyc, 32'd6);

      // Gap at bit 10 of entry 1: reload, count only the fresh window
      cfg_write(1, 5'b10110, 1'b1);
      win = WIN_TWO;
      gap_at = 10;
      run_pass(200, 1'b0);
      check_val("t4_nload",   n_load, 32'd2);
      check_val("t4_idx",     32'(last_idx), 32'd1);
      check_val("t4_cnt",     32'(last_cnt_a), 32'd2);
      check_val("t4_rep_cyc", rep_cyc, 32'd49);
      check_val("t4_done_cyc", done_cyc, 32'd53);

      // Pattern 00000, all-zero window: 28 hits, saturates at 3 with CNT_W = 2
      cfg_write(1, 5'b10110, 1'b0);
      cfg_write(3, 5'b00000, 1'b1);
      win = 32'h0;
      run_pass(200, 1'b0);
      check_val("t5_idx",      32'(last_idx), 32'd3);
      check_val("t5_cnt",      32'(last_cnt_a), 32'd28);
      check_val("t5_cnt_sat",  32'(last_cnt_b), 32'd3);
      check_val("t5_done_cyc", done_cyc, 32'd40);

      // Reset in the middle of SCAN
      cfg_write(3, 5'b00000, 1'b0);
      cfg_write(0, 5'b10110, 1'b1);
      win = WIN_TWO;
      n_hit = 0; n_done = 0; cyc = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (9) tick();
      check_val("t6_in_scan", 32'(din_ready_a), 32'd1);
      resetn = 1'b0;
      #1;
      check_val("t6_det_resetn_now", 32'(det_resetn_a), 32'd0);
      tick();
      check_val("t6_busy",      32'(busy_a),      32'd0);
      check_val("t6_done",      32'(done_a),      32'd0);
      check_val("t6_din_ready", 32'(din_ready_a), 32'd0);
      check_val("t6_det_init",  32'(det_init_a),  32'd0);
      check_val("t6_hit_valid", 32'(hit_valid_a), 32'd0);
      check_val("t6_hit_idx",   32'(hit_idx_a),   32'd0);
      check_val("t6_hit_cnt",   32'(hit_cnt_a),   32'd0);
      resetn = 1'b1;
      repeat (45) tick();
      check_val("t6_no_done", n_done, 32'd0);
      check_val("t6_no_hit",  n_hit,  32'd0);
      check_val("t6_idle",    32'(busy_a), 32'd0);

      // Table writes while busy are ignored
      cfg_write(0, 5'b10110, 1'b1);
      run_pass(200, 1'b1);
      check_val("t7_nhit",     n_hit, 32'd1);
      check_val("t7_done_cyc", done_cyc, 32'd41);
      run_pass(200, 1'b0);
      check_val("t7b_nhit", n_hit, 32'd1);
      check_val("t7b_idx",  32'(last_idx), 32'd0);
      check_val("t7b_init", 32'(last_init), 32'(5'b10110));
      check_val("t7b_cnt",  32'(last_cnt_a), 32'd2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/seq_det_ctrl.md
# seq_det_ctrl

Scan controller for the programmable 5-bit sequence detector. Holds a small table of target patterns and runs them one after another on a single shared detector instance. For each enabled pattern it reloads the detector through its synchronous reset/init port, streams a fixed window of input bits into it, counts detector hits, and reports a per-pattern hit count. It sits between the serial input source and the detector, and owns the detector's `resetn`/`init`/`din` pins.

## Interface
- `NUM_PAT`, default 4: pattern table entries; index width `IW = $clog2(NUM_PAT)`.
- `WIN_LEN`, default 32: input bits streamed per pattern scan; must be ≥ 5.
- `CNT_W`, default 8: hit counter width.

Ports. Clock and reset: one clock; reset is synchronous and active-low.
- `clk`  in  1  clock
- `resetn`  in  1  synchronous active-low reset
- `cfg_we`  in  1  table write strobe
- `cfg_idx`  in  IW  table entry to write
- `cfg_pat`  in  5  target pattern
- `cfg_en`  in  1  entry enable
- `start`  in  1  begin a scan pass
- `busy`  out  1  high in any state other than IDLE
- `done`  out  1  one-cycle pulse at end of pass
- `din_valid`  in  1  input bit valid
- `din`  in  1  input bit
- `din_ready`  out  1  controller accepting bits
- `det_resetn`  out  1  detector reset (active-low)
- `det_init`  out  5  detector target pattern
- `det_din`  out  1  detector input bit
- `det_seen`  in  1  detector hit; registered, high the cycle after the 5th matching bit
- `hit_valid`  out  1  one-cycle report strobe
- `hit_idx`  out  IW  pattern index of the report
- `hit_cnt`  out  CNT_W  hits in the window

## Operation
- Table:
  - `cfg_we` writes `{cfg_en, cfg_pat}` to `cfg_idx`, only in IDLE. Writes in any other state are ignored.
  - On reset, all entries become pattern 0 with enable 0.
- FSM states: IDLE, SEEK, LOAD, SCAN, DRAIN, REPORT, DONE.
- **IDLE**: `start` = 1 → SEEK with `idx` = 0. `start` in other states is ignored.
- **SEEK**: finds the first enabled entry at index ≥ `idx`.
  - Found → LOAD.
  - None found → DONE.
  - One cycle per entry examined.
- **LOAD** (1 cycle):
  - `det_resetn` = 0, `det_init` = `pat[idx]`.
  - Clears `hit_cnt` and `bit_cnt` → SCAN.
- **SCAN**:
  - `din_ready` = 1, `det_din` = `din` (combinational).
  - Each cycle with `din_valid` = 1 increments `bit_cnt`.
  - When `bit_cnt` reaches `WIN_LEN` → DRAIN.
  - A cycle with `din_valid` = 0 is a gap: abort the window, discard the count, and go to LOAD for the same `idx` (the detector is reloaded).
- **DRAIN** (1 cycle): `din_ready` = 0, so the last window bit's hit can be captured → REPORT.
- **Hit counting**: `det_seen` is counted in every SCAN cycle after the first, and in the DRAIN cycle. The counter saturates at 2^CNT_W − 1 and never wraps.
- **REPORT** (1 cycle):
  - `hit_valid` = 1 with `hit_idx` = `idx` and `hit_cnt`.
  - `idx` = `idx` + 1 → SEEK.
  - If `idx` = `NUM_PAT` − 1 → DONE (see Configuration).
- **DONE** (1 cycle): `done` = 1 → IDLE.
- Outside LOAD:
  - `det_resetn` = 1.
  - `det_init` holds its last value; reset value is 0.
- Outside SCAN: `det_din` = 0 and `din_ready` = 0.
- **Reset mid-operation**:
  - All state returns to IDLE immediately, with no report and no done.
  - `det_resetn` = 0 during reset.

## Timing
- Reset values: `busy` = 0, `done` = 0, `din_ready` = 0, `det_resetn` = 0 while `resetn` = 0 (1 after), `det_init` = 0, `det_din` = 0, `hit_valid` = 0, `hit_idx` = 0, `hit_cnt` = 0.
- Timeline for `start` sampled at edge T with entry 0 enabled:
  - SEEK in cycle T+1, LOAD in T+2.
  - SCAN from T+3 through T+2+`WIN_LEN` (gap-free).
  - DRAIN, then REPORT at T+4+`WIN_LEN`.
- Per-pattern cost is 4 + `WIN_LEN` cycles plus skipped entries.
- `hit_idx` and `hit_cnt` hold their values after REPORT until the next REPORT.
- `busy` is high from T+1 through the DONE cycle inclusive.

## Configuration
- `SEQ_DET_CTRL_LOOP_EN`:
  - **Defined**: after the last index, go to SEEK with `idx` = 0 if `start` = 1 in the REPORT cycle. The controller scans continuously while `start` is held. With `start` = 0 it goes to DONE.
  - **Undefined**: single pass. `start` is treated as a pulse, and REPORT of the last index always goes to DONE.

## Test plan
- Entry 0 = 5'b10110 enabled, others disabled; 32-bit window containing "10110" at offsets 3 and 20 → one `hit_valid` with `hit_idx` = 0, `hit_cnt` = 2, then `done`.
- Entry 2 = 5'b11111 enabled; window of 7 consecutive ones then zeros → `hit_cnt` = 3 (overlapping matches). Pattern ending exactly on window bit 32 → counted via DRAIN.
- All entries disabled; `start` → no `hit_valid`, `done` at T+1+`NUM_PAT`+1, `busy` low after.
- `din_valid` dropped for 1 cycle at bit 10 of entry 1 → `det_resetn` pulses low again, bit count restarts, reported count covers only the fresh 32 bits.
- `CNT_W` = 2, pattern 5'b00000, all-zero window → `hit_cnt` = 3 (saturated).
- `resetn` low mid-SCAN → next cycle all outputs at reset values, no `done`. `cfg_we` during `busy` → table unchanged.
